// File: rtl/chu_io_pkg.sv
// Shared definitions for the FPro MMIO SPI slot: register offsets and engine states.
package chu_io_pkg;

    localparam logic [4:0] SPI_RD_REG   = 5'd0;
    localparam logic [4:0] SPI_SS_REG   = 5'd1;
    localparam logic [4:0] SPI_WR_REG   = 5'd2;
    localparam logic [4:0] SPI_CTRL_REG = 5'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPHA_DLY = 2'd1,
        P0       = 2'd2,
        P1       = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_engine.sv
// Single-byte SPI master: MSB first, programmable half-period divisor, CPOL/CPHA modes.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | ready, waiting for start; sclk rests at cpol
//  CPHA_DLY | cpha=1 only: half-period lead-in before the first edge
//  P0       | first half of a bit; miso sampled at its end
//  P1       | second half of a bit; next bit shifted out at its end
module spi_master_engine
    import chu_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  din,
    input  logic        start,
    input  logic [15:0] dvsr,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        miso,
    output logic [7:0]  dout,
    output logic        ready,
    output logic        done_tick,
    output logic        sclk,
    output logic        mosi
);

    spi_state_t  r_state, w_state_nxt;
    logic [15:0] r_c, w_c_nxt;
    logic [2:0]  r_n, w_n_nxt;
    logic [7:0]  r_sin, w_sin_nxt;
    logic [7:0]  r_sout, w_sout_nxt;
    logic [7:0]  r_rx, w_rx_nxt;
    logic        r_sclk;
    logic        r_mosi;
    logic        w_done;
    logic        w_c_tc;
    logic        w_pclk;

    assign w_c_tc = (r_c == dvsr);

    // State, counters, shift registers and registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_c     <= '0;
            r_n     <= '0;
            r_sin   <= '0;
            r_sout  <= '0;
            r_rx    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_n     <= w_n_nxt;
            r_sin   <= w_sin_nxt;
            r_sout  <= w_sout_nxt;
            r_rx    <= w_rx_nxt;
            r_sclk  <= w_pclk ^ cpol;
            // Registered from the next shift value so mosi is valid as soon as the bit phase starts
            r_mosi  <= w_sout_nxt[7];
        end
    end

    // Next-state logic: each phase lasts dvsr+1 clocks
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_n_nxt     = r_n;
        w_sin_nxt   = r_sin;
        w_sout_nxt  = r_sout;
        w_rx_nxt    = r_rx;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_sout_nxt  = din;
                    w_c_nxt     = '0;
                    w_n_nxt     = '0;
                    w_state_nxt = cpha ? CPHA_DLY : P0;
                end
            end
            CPHA_DLY: begin
                if (w_c_tc) begin
                    w_c_nxt     = '0;
                    w_state_nxt = P0;
                end else begin
                    w_c_nxt = r_c + 16'd1;
                end
            end
            P0: begin
                if (w_c_tc) begin
                    w_sin_nxt   = {r_sin[6:0], miso};
                    w_c_nxt     = '0;
                    w_state_nxt = P1;
                end else begin
                    w_c_nxt = r_c + 16'd1;
                end
            end
            P1: begin
                if (w_c_tc) begin
                    w_c_nxt = '0;
                    if (r_n == 3'd7) begin
                        w_state_nxt = IDLE;
                        w_rx_nxt    = r_sin;
                        w_done      = 1'b1;
                    end else begin
                        w_n_nxt     = r_n + 3'd1;
                        w_sout_nxt  = {r_sout[6:0], 1'b0};
                        w_state_nxt = P0;
                    end
                end else begin
                    w_c_nxt = r_c + 16'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_pclk    = ((w_state_nxt == P1) && !cpha) || ((w_state_nxt == P0) && cpha);
    assign ready     = (r_state == IDLE);
    assign done_tick = w_done;
    assign dout      = r_rx;
    assign sclk      = r_sclk;
    assign mosi      = r_mosi;

endmodule

// File: rtl/chu_spi_acl_core.sv
// FPro MMIO slot wrapper for the accelerometer SPI master: slot registers and read mux.
module chu_spi_acl_core
    import chu_io_pkg::*;
#(
    parameter int S        = 1,
    parameter int DVSR_RST = 49
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic         spi_sclk,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [S-1:0] spi_ss_n
);

    logic [S-1:0] r_ss_n;
    logic [15:0]  r_dvsr;
    logic         r_cpol;
    logic         r_cpha;
    logic         w_wr_en;
    logic         w_start;
    logic         w_ready;
    logic         w_done_tick;
    logic [7:0]   w_rx;

    assign w_wr_en = cs && write;
    // A start while busy is dropped rather than queued
    assign w_start = w_wr_en && (addr == SPI_WR_REG) && w_ready;

    // Slave-select and control registers; config writes apply immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ss_n <= '1;
            r_dvsr <= 16'(DVSR_RST);
            r_cpol <= 1'b0;
            r_cpha <= 1'b0;
        end else if (w_wr_en) begin
            if (addr == SPI_SS_REG) begin
                r_ss_n <= wr_data[S-1:0];
            end
            if (addr == SPI_CTRL_REG) begin
                r_dvsr <= wr_data[15:0];
                r_cpol <= wr_data[16];
                r_cpha <= wr_data[17];
            end
        end
    end

    spi_master_engine u_engine (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (wr_data[7:0]),
        .start     (w_start),
        .dvsr      (r_dvsr),
        .cpol      (r_cpol),
        .cpha      (r_cpha),
        .miso      (spi_miso),
        .dout      (w_rx),
        .ready     (w_ready),
        .done_tick (w_done_tick),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi)
    );

    // Combinational read mux; only the status/data word is readable
    always_comb begin
        rd_data = '0;
        if (cs && read && (addr == SPI_RD_REG)) begin
            rd_data = {23'b0, w_ready, w_rx};
        end
    end

    assign spi_ss_n = r_ss_n;

endmodule
